// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard/stall controller.
// NOP_INST is the encoding of add r0,r0,r0 that decode injects as a bubble.
package hazard_ctrl_pkg;

    localparam int          STALL_CNT_WIDTH = 16;
    localparam logic [31:0] NOP_INST        = 32'h0000_0033;

    typedef enum logic [2:0] {
        HZ_RUN       = 3'd0,
        HZ_DC_WAIT   = 3'd1,
        HZ_IC_WAIT   = 3'd2,
        HZ_LU_BUBBLE = 3'd3,
        HZ_FLUSH     = 3'd4
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the decode sources and the ALU-stage load.
// Register 0 is hard-wired, so a load targeting it never creates a dependency.
module load_use_detect #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] dec_addrA,
    input  logic [ADDR_WIDTH-1:0] dec_addrB,
    input  logic                  dec_uses_a,
    input  logic                  dec_uses_b,
    input  logic                  alu_mem_r_en,
    input  logic [ADDR_WIDTH-1:0] alu_regD,
    output logic                  lu
);

    logic hit_a;
    logic hit_b;

    assign hit_a = dec_uses_a && (dec_addrA == alu_regD);
    assign hit_b = dec_uses_b && (dec_addrB == alu_regD);
    assign lu    = alu_mem_r_en && (alu_regD != '0) && (hit_a || hit_b);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, NOP-bubble select, fetch flush,
// a pending-flush flag that survives data-cache freezes, and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = STALL_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] dec_addrA,
    input  logic [ADDR_WIDTH-1:0] dec_addrB,
    input  logic                  dec_uses_a,
    input  logic                  dec_uses_b,
    input  logic                  alu_mem_r_en,
    input  logic [ADDR_WIDTH-1:0] alu_regD,
    input  logic                  branch_taken,
    input  logic                  block_pipe_data_cache,
    input  logic                  block_pipe_instr_cache,
    input  logic                  clear_stats,
    output logic                  EN_REG_FETCH,
    output logic                  EN_REG_DECODE,
    output logic                  EN_REG_ALU,
    output logic                  EN_REG_MEM,
    output logic                  injecting_nop,
    output logic [INST_WIDTH-1:0] inject_nop,
    output logic                  flush_fetch,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [2:0]            state
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    hz_state_t            state_q;
    hz_state_t            state_d;
    logic                 pending_flush_q;
    logic                 pending_flush_d;
    logic                 lu;
    logic                 flush_due;
    logic                 stall_cycle;
    logic [CNT_WIDTH-1:0] stall_count_q;

    load_use_detect #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_load_use_detect (
        .dec_addrA   (dec_addrA),
        .dec_addrB   (dec_addrB),
        .dec_uses_a  (dec_uses_a),
        .dec_uses_b  (dec_uses_b),
        .alu_mem_r_en(alu_mem_r_en),
        .alu_regD    (alu_regD),
        .lu          (lu)
    );

    // A second flush bubble is owed either in FLUSH or after a freeze that interrupted it.
    assign flush_due = (state_q == HZ_FLUSH) || pending_flush_q;

    always_comb begin
        EN_REG_FETCH    = 1'b1;
        EN_REG_DECODE   = 1'b1;
        EN_REG_ALU      = 1'b1;
        EN_REG_MEM      = 1'b1;
        injecting_nop   = 1'b0;
        flush_fetch     = 1'b0;
        state_d         = HZ_RUN;
        pending_flush_d = 1'b0;

        if (block_pipe_data_cache) begin
            EN_REG_FETCH    = 1'b0;
            EN_REG_DECODE   = 1'b0;
            EN_REG_ALU      = 1'b0;
            EN_REG_MEM      = 1'b0;
            state_d         = HZ_DC_WAIT;
            pending_flush_d = flush_due;
        end else if (block_pipe_instr_cache) begin
            EN_REG_FETCH  = 1'b0;
            injecting_nop = 1'b1;
            state_d       = HZ_IC_WAIT;
        end else if (branch_taken) begin
            injecting_nop = 1'b1;
            flush_fetch   = 1'b1;
            state_d       = HZ_FLUSH;
        end else if (flush_due) begin
            injecting_nop = 1'b1;
            state_d       = HZ_RUN;
        end else if (lu) begin
            EN_REG_FETCH  = 1'b0;
            injecting_nop = 1'b1;
            state_d       = HZ_LU_BUBBLE;
        end

        // Reset holds the pipe still with a bubble selected, regardless of inputs.
        if (reset) begin
            EN_REG_FETCH  = 1'b0;
            EN_REG_DECODE = 1'b0;
            EN_REG_ALU    = 1'b0;
            EN_REG_MEM    = 1'b0;
            injecting_nop = 1'b1;
            flush_fetch   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= HZ_RUN;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    assign stall_cycle = !EN_REG_FETCH || injecting_nop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (clear_stats) begin
            stall_count_q <= '0;
        end else if (stall_cycle) begin
            stall_count_q <= sat_inc(stall_count_q);
        end
    end

    assign stall_count = stall_count_q;
    assign state       = state_q;
    assign inject_nop  = INST_WIDTH'(NOP_INST);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  dec_addrA = '0, dec_addrB = '0, alu_regD = '0;
    logic        dec_uses_a = 1'b0, dec_uses_b = 1'b0, alu_mem_r_en = 1'b0;
    logic        branch_taken = 1'b0, dc = 1'b0, ic = 1'b0, clear_stats = 1'b0;
    logic        EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM;
    logic        injecting_nop, flush_fetch;
    logic [31:0] inject_nop;
    logic [15:0] stall_count;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    // Behavioural model: last cycle's winning condition, owed flush bubble, stall tally.
    int m_state = 0;
    bit m_owe = 1'b0;
    int m_cnt = 0;
    int p_state;
    bit p_owe;
    int p_cnt;
    bit [3:0] p_en;
    bit p_nop, p_flush;

    hazard_ctrl #(.ADDR_WIDTH(5), .INST_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .dec_addrA(dec_addrA), .dec_addrB(dec_addrB),
        .dec_uses_a(dec_uses_a), .dec_uses_b(dec_uses_b),
        .alu_mem_r_en(alu_mem_r_en), .alu_regD(alu_regD),
        .branch_taken(branch_taken),
        .block_pipe_data_cache(dc), .block_pipe_instr_cache(ic),
        .clear_stats(clear_stats),
        .EN_REG_FETCH(EN_REG_FETCH), .EN_REG_DECODE(EN_REG_DECODE),
        .EN_REG_ALU(EN_REG_ALU), .EN_REG_MEM(EN_REG_MEM),
        .injecting_nop(injecting_nop), .inject_nop(inject_nop),
        .flush_fetch(flush_fetch), .stall_count(stall_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        dec_addrA = '0; dec_addrB = '0; alu_regD = '0;
        dec_uses_a = 0; dec_uses_b = 0; alu_mem_r_en = 0;
        branch_taken = 0; dc = 0; ic = 0; clear_stats = 0;
    endtask

    task automatic model_eval();
        bit hit;
        hit = alu_mem_r_en && (alu_regD != 0) &&
              ((dec_uses_a && dec_addrA == alu_regD) || (dec_uses_b && dec_addrB == alu_regD));
        p_flush = 0;
        if (dc) begin
            p_en = 4'b0000; p_nop = 0; p_state = 1; p_owe = m_owe;
        end else if (ic) begin
            p_en = 4'b0111; p_nop = 1; p_state = 2; p_owe = 0;
        end else if (branch_taken) begin
            p_en = 4'b1111; p_nop = 1; p_flush = 1; p_state = 4; p_owe = 1;
        end else if (m_owe) begin
            p_en = 4'b1111; p_nop = 1; p_state = 0; p_owe = 0;
        end else if (hit) begin
            p_en = 4'b0111; p_nop = 1; p_state = 3; p_owe = 0;
        end else begin
            p_en = 4'b1111; p_nop = 0; p_state = 0; p_owe = 0;
        end
        if (clear_stats) p_cnt = 0;
        else if (!p_en[3] || p_nop) p_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        else p_cnt = m_cnt;
    endtask

    // Inputs are already driven (after a negedge); check comb outputs, clock, check state.
    task automatic tick_check(input string tag);
        #1;
        model_eval();
        chk({tag, ".en"}, int'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), int'(p_en));
        chk({tag, ".nop"}, int'(injecting_nop), int'(p_nop));
        chk({tag, ".flush"}, int'(flush_fetch), int'(p_flush));
        @(posedge clk);
        m_state = p_state; m_owe = p_owe; m_cnt = p_cnt;
        #1;
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".cnt"}, int'(stall_count), m_cnt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        m_state = 0; m_owe = 0; m_cnt = 0;
    endtask

    typedef struct {
        bit dc, ic, br, ld, ua, ub;
        logic [4:0] a, b, d;
        bit [3:0] en;
        bit nop, fl;
        int nst;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 0, 0};
        vecs[1] = '{0,0,0,1,1,0, 5'd3, 5'd0, 5'd3, 4'b0111, 1, 0, 3};
        vecs[2] = '{0,0,0,1,0,1, 5'd1, 5'd7, 5'd7, 4'b0111, 1, 0, 3};
        vecs[3] = '{0,0,0,1,0,0, 5'd3, 5'd3, 5'd3, 4'b1111, 0, 0, 0};
        vecs[4] = '{0,0,0,1,1,1, 5'd0, 5'd0, 5'd0, 4'b1111, 0, 0, 0};
        vecs[5] = '{0,0,0,0,1,0, 5'd3, 5'd0, 5'd3, 4'b1111, 0, 0, 0};
        vecs[6] = '{0,0,1,1,1,0, 5'd3, 5'd0, 5'd3, 4'b1111, 1, 1, 4};
        vecs[7] = '{0,1,0,1,1,0, 5'd3, 5'd0, 5'd3, 4'b0111, 1, 0, 2};
        vecs[8] = '{1,0,1,0,0,0, 5'd0, 5'd0, 5'd0, 4'b0000, 0, 0, 1};
        vecs[9] = '{1,1,0,1,1,0, 5'd3, 5'd0, 5'd3, 4'b0000, 0, 0, 1};

        // Reset state, checked while reset is held.
        @(negedge clk);
        #1;
        chk("rst.en", int'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), 0);
        chk("rst.nop", int'(injecting_nop), 1);
        chk("rst.flush", int'(flush_fetch), 0);
        chk("rst.state", int'(state), 0);
        chk("rst.cnt", int'(stall_count), 0);
        chk("nop_inst", int'(inject_nop), 32'h33);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            dc = vecs[i].dc; ic = vecs[i].ic; branch_taken = vecs[i].br;
            alu_mem_r_en = vecs[i].ld; dec_uses_a = vecs[i].ua; dec_uses_b = vecs[i].ub;
            dec_addrA = vecs[i].a; dec_addrB = vecs[i].b; alu_regD = vecs[i].d;
            #1;
            chk($sformatf("vec%0d.en", i),
                int'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), int'(vecs[i].en));
            chk($sformatf("vec%0d.nop", i), int'(injecting_nop), int'(vecs[i].nop));
            chk($sformatf("vec%0d.flush", i), int'(flush_fetch), int'(vecs[i].fl));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.state", i), int'(state), vecs[i].nst);
        end

        // Load-use: one bubble then RUN.
        do_reset();
        alu_mem_r_en = 1; alu_regD = 3; dec_addrA = 3; dec_uses_a = 1;
        tick_check("lu0");
        chk("lu.state_bubble", int'(state), 3);
        idle_inputs();
        tick_check("lu1");
        chk("lu.state_run", int'(state), 0);
        chk("lu.cnt", int'(stall_count), 1);

        // Same with r0 as destination: no stall.
        do_reset();
        alu_mem_r_en = 1; alu_regD = 0; dec_addrA = 0; dec_uses_a = 1;
        tick_check("lu_r0");
        chk("lu_r0.cnt", int'(stall_count), 0);

        // Branch pulse: two bubbles, flush on the first.
        do_reset();
        branch_taken = 1;
        tick_check("br0");
        idle_inputs();
        tick_check("br1");
        tick_check("br2");
        chk("br.state_run", int'(state), 0);
        chk("br.cnt", int'(stall_count), 2);

        // Data-cache freeze during FLUSH keeps the owed bubble.
        do_reset();
        branch_taken = 1;
        tick_check("dcf_br");
        idle_inputs();
        dc = 1;
        for (int i = 0; i < 4; i++) tick_check($sformatf("dcf_frz%0d", i));
        dc = 0;
        #1;
        chk("dcf.bubble_nop", int'(injecting_nop), 1);
        chk("dcf.bubble_en", int'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), 15);
        tick_check("dcf_bub");
        #1;
        chk("dcf.after_nop", int'(injecting_nop), 0);
        tick_check("dcf_run");
        chk("dcf.cnt", int'(stall_count), 6);

        // Icache busy together with lu, then saturation and clear.
        do_reset();
        ic = 1; alu_mem_r_en = 1; alu_regD = 4; dec_addrB = 4; dec_uses_b = 1;
        tick_check("iclu");
        for (int i = 0; i < 70000; i++) @(posedge clk);
        @(negedge clk);
        chk("sat.cnt", int'(stall_count), 16'hFFFF);
        m_cnt = 65535; m_state = 2;
        clear_stats = 1;
        tick_check("clr");
        chk("clr.cnt_zero", int'(stall_count), 0);

        // Async reset mid-FLUSH aborts the owed bubble.
        do_reset();
        branch_taken = 1;
        tick_check("arst_br");
        idle_inputs();
        #2;
        reset = 1;
        #1;
        chk("arst.en", int'({EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM}), 0);
        chk("arst.nop", int'(injecting_nop), 1);
        chk("arst.state", int'(state), 0);
        chk("arst.cnt", int'(stall_count), 0);
        @(negedge clk);
        reset = 0;
        m_state = 0; m_owe = 0; m_cnt = 0;
        tick_check("arst_after");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            dc = ($urandom_range(0, 9) == 0);
            ic = ($urandom_range(0, 9) == 0);
            branch_taken = !ic && ($urandom_range(0, 9) == 0);
            alu_mem_r_en = $urandom_range(0, 1);
            alu_regD = 5'($urandom_range(0, 3));
            dec_addrA = 5'($urandom_range(0, 3));
            dec_addrB = 5'($urandom_range(0, 3));
            dec_uses_a = $urandom_range(0, 1);
            dec_uses_b = $urandom_range(0, 1);
            clear_stats = ($urandom_range(0, 49) == 0);
            tick_check("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
